// File: rtl/seg7_pkg.sv
// seg7_pkg: digit-scan states, blanking constants and the active-low hex segment table
package seg7_pkg;

    typedef enum logic {
        S_ONES = 1'b0,
        S_TENS = 1'b1
    } digit_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [1:0] AN_OFF    = 2'b11;

    // Entry n is the {g,f,e,d,c,b,a} active-low pattern for hex digit n (listed F down to 0)
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational 4-bit to active-low 7-segment decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered two-digit 7-segment scanner with anti-ghost blanking (option SEG7_LZ_BLANK_EN blanks a zero tens digit)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] value_in,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       pending,
    output logic       frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] r_cnt;
    digit_state_t  r_state;
    digit_state_t  w_state_nxt;
    logic [5:0]    r_shadow;
    logic [5:0]    r_disp;
    logic          r_pending;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;
    logic          w_tick;
    logic          w_blank;
    logic          w_lz;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;
    logic [6:0]    w_seg_nxt;
    logic [1:0]    w_an_nxt;

    assign w_tick     = r_cnt == CW'(REFRESH_DIV - 1);
    assign w_blank    = r_cnt < CW'(BLANK_CYC);
    assign frame_done = w_tick && (r_state == S_TENS);
    assign w_nib      = (r_state == S_ONES) ? r_disp[3:0] : {2'b00, r_disp[5:4]};
    assign seg        = r_seg;
    assign an         = r_an;
    assign pending    = r_pending;

`ifdef SEG7_LZ_BLANK_EN
    assign w_lz = (r_state == S_TENS) && (r_disp[5:4] == 2'b00);
`else
    assign w_lz = 1'b0;
`endif

    seg7_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_hex)
    );

    // Refresh counter: one full count is one digit slot
    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end

    // Digit-scan state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_ONES;
        else       r_state <= w_state_nxt;
    end

    // Next digit on each slot tick; next-cycle anode/segment drive with blanking at slot start
    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = AN_OFF;
        w_seg_nxt   = SEG_BLANK;
        if (w_tick) w_state_nxt = (r_state == S_ONES) ? S_TENS : S_ONES;
        w_an_nxt  = w_blank ? AN_OFF : ((r_state == S_ONES) ? 2'b10 : 2'b01);
        w_seg_nxt = (w_blank || w_lz) ? SEG_BLANK : w_hex;
    end

    // Shadow captures loads; disp only updates at frame end so a frame never tears
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (frame_done && r_pending) begin
                r_disp    <= r_shadow;
                r_pending <= 1'b0;
            end
            if (load) begin
                r_shadow  <= value_in;
                r_pending <= 1'b1;
            end
        end
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= SEG_BLANK;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench comparing the scanner against a frame-position reference model
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 2 * DIV;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] an;
        logic       pend;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] value_in;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       pending;
    logic       frame_done;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_t    = 0;
    int   m_shadow = 0;
    int   m_disp   = 0;
    int   m_pend   = 0;

    seg7_scan_driver #(
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input int n);
        case (n)
            0:  hex7 = 7'b1000000;
            1:  hex7 = 7'b1111001;
            2:  hex7 = 7'b0100100;
            3:  hex7 = 7'b0110000;
            4:  hex7 = 7'b0011001;
            5:  hex7 = 7'b0010010;
            6:  hex7 = 7'b0000010;
            7:  hex7 = 7'b1111000;
            8:  hex7 = 7'b0000000;
            9:  hex7 = 7'b0010000;
            10: hex7 = 7'b0001000;
            11: hex7 = 7'b0000011;
            12: hex7 = 7'b1000110;
            13: hex7 = 7'b0100001;
            14: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] tens_seg(input int d);
`ifdef SEG7_LZ_BLANK_EN
        tens_seg = (d / 16 == 0) ? 7'h7F : hex7(d / 16);
`else
        tens_seg = hex7(d / 16);
`endif
    endfunction

    // Reference model: position within the frame decides what the display shows one cycle later
    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            e = '{seg: 7'h7F, an: 2'b11, pend: 1'b0, fd: 1'b0};
            m_t = 0; m_shadow = 0; m_disp = 0; m_pend = 0;
        end else begin
            if (m_t % DIV < BLANK) begin
                e.seg = 7'h7F; e.an = 2'b11;
            end else if (m_t < DIV) begin
                e.seg = hex7(m_disp % 16); e.an = 2'b10;
            end else begin
                e.seg = tens_seg(m_disp); e.an = 2'b01;
            end
            if (m_t == FRAME - 1 && m_pend != 0) begin
                m_disp = m_shadow; m_pend = 0;
            end
            if (load) begin
                m_shadow = int'(value_in); m_pend = 1;
            end
            m_t = (m_t + 1) % FRAME;
            e.pend = (m_pend != 0);
            e.fd   = (m_t == FRAME - 1);
        end
        q.push_back(e);
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, pop the expected entry and compare
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seg", seg, e.seg);
            chk("an", {5'b0, an}, {5'b0, e.an});
            chk("pending", {6'b0, pending}, {6'b0, e.pend});
            chk("frame_done", {6'b0, frame_done}, {6'b0, e.fd});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [5:0] v);
        value_in = v;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic wait_t(input int k);
        for (int i = 0; i < 3 * FRAME && m_t != k; i++) step();
        n_chk++;
        if (m_t != k) begin
            n_fail++;
            $display("FAIL wait_pos: got %0d want %0d", m_t, k);
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value_in = '0;
        repeat (5) step();
        reset = 1'b0;
        repeat (FRAME + 4) step();
        do_load(6'h2B);
        repeat (3 * FRAME) step();
        do_load(6'h05);
        repeat (3) step();
        do_load(6'h3F);
        repeat (3 * FRAME) step();
        wait_t(FRAME - 1);
        do_load(6'h11);
        repeat (3 * FRAME) step();
        wait_t(2);
        do_load(6'h22);
        wait_t(DIV + 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3 * FRAME) step();
        do_load(6'h0A);
        repeat (3 * FRAME) step();
        for (int i = 0; i < 400; i++) begin
            value_in = 6'($urandom);
            load     = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            step();
        end
        load  = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
